text_render_pipeline: RTL and testbench

Read-side consumer of the text-mode memories. The block turns the video timing generator's pixel coordinates into 6-bit RGB pixels. Each pixel goes through a fixed 5-cycle pipeline:

1. Fetch the cell from the character buffer (port B).
2. Fetch the glyph row from the font ROM.
3. Resolve the foreground and background colours through the colour palette.

It sits between the timing generator and the VGA output register, and delays the sync and active signals so they stay aligned with the pixel data.

---
 rtl/text_render_pipeline_pkg.sv | 30 +++
 rtl/text_addr_gen.sv | 45 ++++
 rtl/text_render_pipeline.sv | 124 ++++++++++++
 tb/tb_text_render_pipeline.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_render_pipeline_pkg.sv
// Shared constants and types for the text-mode render pipeline:
// screen geometry, pipeline latency, cell field split and the sideband record.
package text_render_pipeline_pkg;

  localparam int COLS        = 80;
  localparam int SCREEN_ROWS = 30;
  localparam int RING_ROWS   = 32;
  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int PIPE_LAT    = 5;

  // A character cell is {attr[7:0], code[7:0]}; attr is {bg[3:0], fg[3:0]}.
  localparam int ATTR_MSB = 15;
  localparam int ATTR_LSB = 8;
  localparam int CODE_MSB = 7;
  localparam int CODE_LSB = 0;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [2:0] px;
    logic [3:0] grow;
    logic       cursor;
  } side_t;

  localparam side_t SIDE_RESET = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0,
                                   px: 3'd0, grow: 4'd0, cursor: 1'b0};

endpackage

// File: rtl/text_addr_gen.sv
// Stage 0 of the text pipeline: latches the ring start row once per frame
// and maps screen (col, row) onto a character-buffer address.
module text_addr_gen #(
  parameter int COLS      = 80,
  parameter int RING_ROWS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_vsync,
  input  logic [4:0]  i_start_row,
  input  logic [6:0]  i_col,
  input  logic [4:0]  i_scr_row,
  input  logic        i_valid,
  output logic [11:0] o_char_addr,
  output logic        o_vsync_fall
);

  logic        r_vsync_prev;
  logic [4:0]  r_start_row_q;
  logic [5:0]  w_row_sum;
  logic [4:0]  w_ring_row;
  logic [11:0] w_addr;

  assign o_vsync_fall = r_vsync_prev && !i_vsync;

  assign w_row_sum  = {1'b0, i_scr_row} + {1'b0, r_start_row_q};
  assign w_ring_row = (w_row_sum >= 6'(RING_ROWS)) ? 5'(w_row_sum - 6'(RING_ROWS))
                                                   : w_row_sum[4:0];
  assign w_addr     = 12'(w_ring_row) * 12'(COLS) + 12'(i_col);

  // The start row only moves at the start of vsync so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vsync_prev  <= 1'b1;
      r_start_row_q <= 5'd0;
      o_char_addr   <= 12'd0;
    end else begin
      r_vsync_prev <= i_vsync;
      if (o_vsync_fall)
        r_start_row_q <= i_start_row;
      o_char_addr <= i_valid ? w_addr : 12'd0;
    end
  end

endmodule

// File: rtl/text_render_pipeline.sv
// Five-clock text-mode renderer: pixel coordinates in, 6-bit RGB out, with
// syncs delayed to match. Optional blinking cursor under `TEXT_CURSOR_EN.
module text_render_pipeline
  import text_render_pipeline_pkg::*;
#(
  parameter int COLS      = 80,
  parameter int RING_ROWS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [4:0]  start_row,
  output logic [11:0] char_addr,
  input  logic [15:0] char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  pal_fg_addr,
  output logic [3:0]  pal_bg_addr,
  input  logic [5:0]  pal_fg_data,
  input  logic [5:0]  pal_bg_data,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_on,
  output logic [5:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out
);

  localparam int LAST = PIPE_LAT - 2;

  logic       w_issue;
  logic       w_vsync_fall;
  logic       w_cursor_hit;
  logic       w_pix_bit;
  logic       w_sel_fg;
  logic [7:0] w_attr;
  side_t      w_side_in;
  side_t      r_side [PIPE_LAT-1];

  assign w_issue = video_active && (pixel_x < 10'd640);

  text_addr_gen #(
    .COLS      (COLS),
    .RING_ROWS (RING_ROWS)
  ) u_addr_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_vsync      (vsync_in),
    .i_start_row  (start_row),
    .i_col        (pixel_x[9:3]),
    .i_scr_row    (pixel_y[8:4]),
    .i_valid      (w_issue),
    .o_char_addr  (char_addr),
    .o_vsync_fall (w_vsync_fall)
  );

`ifdef TEXT_CURSOR_EN
  logic [4:0] r_blink_cnt;
  logic       w_unused;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_blink_cnt <= 5'd0;
    else if (w_vsync_fall)
      r_blink_cnt <= r_blink_cnt + 5'd1;
  end

  // Cursor cell is matched in screen coordinates, before the ring offset.
  assign w_cursor_hit = cursor_on && (pixel_x[9:3] == cursor_col) &&
                        (pixel_y[8:4] == cursor_row) && (pixel_y[3:1] == 3'b111) &&
                        r_blink_cnt[4];
  assign w_unused     = pixel_y[9];
`else
  logic w_unused;
  assign w_cursor_hit = 1'b0;
  assign w_unused     = &{1'b0, cursor_col, cursor_row, cursor_on, w_vsync_fall, pixel_y[9]};
`endif

  always_comb begin
    w_side_in        = SIDE_RESET;
    w_side_in.hsync  = hsync_in;
    w_side_in.vsync  = vsync_in;
    w_side_in.active = w_issue;
    w_side_in.px     = pixel_x[2:0];
    w_side_in.grow   = pixel_y[3:0];
    w_side_in.cursor = w_cursor_hit;
  end

  assign w_attr    = char_data[ATTR_MSB:ATTR_LSB];
  assign w_pix_bit = font_data[3'd7 - r_side[LAST].px];
  assign w_sel_fg  = w_pix_bit ^ r_side[LAST].cursor;

  // Sideband rides a shift register so it meets the data at the output stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_LAT - 1; i++)
        r_side[i] <= SIDE_RESET;
      font_addr   <= 12'd0;
      pal_fg_addr <= 4'd0;
      pal_bg_addr <= 4'd0;
      rgb         <= 6'd0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      active_out  <= 1'b0;
    end else begin
      r_side[0] <= w_side_in;
      for (int i = 1; i < PIPE_LAT - 1; i++)
        r_side[i] <= r_side[i-1];
      font_addr   <= {char_data[CODE_MSB:CODE_LSB], r_side[1].grow};
      pal_fg_addr <= w_attr[3:0];
      pal_bg_addr <= w_attr[7:4];
      rgb         <= r_side[LAST].active ? (w_sel_fg ? pal_fg_data : pal_bg_data) : 6'd0;
      hsync_out   <= r_side[LAST].hsync;
      vsync_out   <= r_side[LAST].vsync;
      active_out  <= r_side[LAST].active;
    end
  end

endmodule

// File: tb/tb_text_render_pipeline.sv
// Directed self-checking bench for text_render_pipeline with behavioural
// character buffer, font ROM and palette models.
module tb_text_render_pipeline;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_active, hsync_in, vsync_in;
  logic [4:0]  start_row;
  logic [11:0] char_addr;
  logic [15:0] char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  pal_fg_addr, pal_bg_addr;
  logic [5:0]  pal_fg_data, pal_bg_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_on;
  logic [5:0]  rgb;
  logic        hsync_out, vsync_out, active_out;

  logic [15:0] char_mem [0:4095];
  logic [7:0]  font_mem [0:4095];
  logic [5:0]  pal_mem  [0:15];

  logic [5:0]  cap_rgb  [0:31];
  logic [11:0] cap_addr [0:31];
  logic [11:0] cap_font [0:31];
  logic [3:0]  cap_fg   [0:31];
  logic [3:0]  cap_bg   [0:31];
  logic        cap_hs   [0:31];
  logic        cap_vs   [0:31];
  logic        cap_act  [0:31];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  text_render_pipeline dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_active (video_active),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .start_row    (start_row),
    .char_addr    (char_addr),
    .char_data    (char_data),
    .font_addr    (font_addr),
    .font_data    (font_data),
    .pal_fg_addr  (pal_fg_addr),
    .pal_bg_addr  (pal_bg_addr),
    .pal_fg_data  (pal_fg_data),
    .pal_bg_data  (pal_bg_data),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row),
    .cursor_on    (cursor_on),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .active_out   (active_out)
  );

  // One-clock read latency memories feeding the DUT.
  always @(posedge clk) begin
    char_data   <= char_mem[char_addr];
    font_data   <= font_mem[font_addr];
    pal_fg_data <= pal_mem[pal_fg_addr];
    pal_bg_data <= pal_mem[pal_bg_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pixel(input logic [9:0] x, input logic [9:0] y, input logic act);
    pixel_x      = x;
    pixel_y      = y;
    video_active = act;
  endtask

  task automatic capture(input int n);
    cap_rgb[n]  = rgb;
    cap_addr[n] = char_addr;
    cap_font[n] = font_addr;
    cap_fg[n]   = pal_fg_addr;
    cap_bg[n]   = pal_bg_addr;
    cap_hs[n]   = hsync_out;
    cap_vs[n]   = vsync_out;
    cap_act[n]  = active_out;
  endtask

  task automatic pulse_vsync();
    set_pixel(10'd0, 10'd0, 1'b0);
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    tests_run++;
    if ({rgb, hsync_out, vsync_out, active_out, char_addr, font_addr, pal_fg_addr, pal_bg_addr}
        !== {6'd0, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 4'd0, 4'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got rgb=%h hs=%b vs=%b act=%b ca=%h fa=%h fg=%h bg=%h, expected all zero with syncs 1",
               rgb, hsync_out, vsync_out, active_out, char_addr, font_addr, pal_fg_addr, pal_bg_addr);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if ({rgb, hsync_out, vsync_out, active_out, char_addr} !== {6'd0, 1'b1, 1'b1, 1'b0, 12'd0}) begin
        tests_failed++;
        $display("[TB] FAIL idle[%0d]: got rgb=%h hs=%b vs=%b act=%b ca=%h, expected 00 1 1 0 000",
                 i, rgb, hsync_out, vsync_out, active_out, char_addr);
      end
    end
  endtask

  task automatic test_basic();
    logic [5:0] exp_rgb [0:7];
    exp_rgb = '{6'h00, 6'h00, 6'h00, 6'h2A, 6'h2A, 6'h00, 6'h00, 6'h00};
    for (int n = 0; n < 13; n++) begin
      if (n < 8) set_pixel(10'(n), 10'd0, 1'b1);
      else       set_pixel(10'd0, 10'd0, 1'b0);
      step();
      capture(n);
    end
    tests_run++;
    if (cap_addr[0] !== 12'd0) begin
      tests_failed++;
      $display("[TB] FAIL basic_char_addr: got %h, expected 000", cap_addr[0]);
    end
    tests_run++;
    if ({cap_font[2], cap_fg[2], cap_bg[2]} !== {12'h410, 4'h7, 4'h0}) begin
      tests_failed++;
      $display("[TB] FAIL basic_font_pal: got fa=%h fg=%h bg=%h, expected 410 7 0", cap_font[2], cap_fg[2], cap_bg[2]);
    end
    for (int n = 0; n < 8; n++) begin
      tests_run++;
      if ({cap_rgb[n+4], cap_act[n+4]} !== {exp_rgb[n], 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL basic_rgb[%0d]: got %h act=%b, expected %h act=1", n, cap_rgb[n+4], cap_act[n+4], exp_rgb[n]);
      end
    end
    tests_run++;
    if ({cap_rgb[12], cap_act[12]} !== {6'h00, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL basic_tail: got %h act=%b, expected 00 act=0", cap_rgb[12], cap_act[12]);
    end
  endtask

  task automatic test_attr();
    logic [5:0] exp_rgb [0:7];
    exp_rgb = '{6'h33, 6'h0C, 6'h33, 6'h0C, 6'h0C, 6'h33, 6'h0C, 6'h33};
    for (int n = 0; n < 12; n++) begin
      if (n < 8) set_pixel(10'(8 + n), 10'd2, 1'b1);
      else       set_pixel(10'd0, 10'd0, 1'b0);
      step();
      capture(n);
    end
    tests_run++;
    if ({cap_addr[0], cap_font[2], cap_fg[2], cap_bg[2]} !== {12'd1, 12'h422, 4'hE, 4'h1}) begin
      tests_failed++;
      $display("[TB] FAIL attr_addrs: got ca=%h fa=%h fg=%h bg=%h, expected 001 422 e 1",
               cap_addr[0], cap_font[2], cap_fg[2], cap_bg[2]);
    end
    for (int n = 0; n < 8; n++) begin
      tests_run++;
      if (cap_rgb[n+4] !== exp_rgb[n]) begin
        tests_failed++;
        $display("[TB] FAIL attr_rgb[%0d]: got %h, expected %h", n, cap_rgb[n+4], exp_rgb[n]);
      end
    end
  endtask

  task automatic test_inactive();
    for (int n = 0; n < 7; n++) begin
      if (n == 0)      set_pixel(10'd11, 10'd0, 1'b1);
      else if (n == 1) set_pixel(10'd700, 10'd0, 1'b0);
      else             set_pixel(10'd0, 10'd0, 1'b0);
      step();
      capture(n);
    end
    tests_run++;
    if ({cap_addr[0], cap_addr[1]} !== {12'd1, 12'd0}) begin
      tests_failed++;
      $display("[TB] FAIL inactive_addr: got %h %h, expected 001 000", cap_addr[0], cap_addr[1]);
    end
    tests_run++;
    if ({cap_rgb[4], cap_rgb[5], cap_act[5]} !== {6'h33, 6'h00, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL inactive_rgb: got %h %h act=%b, expected 33 00 act=0", cap_rgb[4], cap_rgb[5], cap_act[5]);
    end
  endtask

  task automatic test_sync_latency();
    for (int n = 0; n < 12; n++) begin
      set_pixel(10'(n), 10'd0, 1'b1);
      hsync_in = (n == 2) ? 1'b0 : 1'b1;
      vsync_in = (n == 4) ? 1'b0 : 1'b1;
      step();
      capture(n);
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    tests_run++;
    if ({cap_hs[5], cap_hs[6], cap_hs[7]} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL hsync_lat: got %b%b%b, expected 101", cap_hs[5], cap_hs[6], cap_hs[7]);
    end
    tests_run++;
    if ({cap_vs[7], cap_vs[8], cap_vs[9]} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL vsync_lat: got %b%b%b, expected 101", cap_vs[7], cap_vs[8], cap_vs[9]);
    end
  endtask

  task automatic test_ring();
    start_row = 5'd31;
    pulse_vsync();
    set_pixel(10'd8, 10'd16, 1'b1);
    step();
    capture(0);
    set_pixel(10'd639, 10'd479, 1'b1);
    step();
    capture(1);
    tests_run++;
    if (cap_addr[0] !== 12'd1) begin
      tests_failed++;
      $display("[TB] FAIL ring_wrap: got %0d, expected 1", cap_addr[0]);
    end
    tests_run++;
    if (cap_addr[1] !== 12'd2319) begin
      tests_failed++;
      $display("[TB] FAIL ring_last: got %0d, expected 2319", cap_addr[1]);
    end
  endtask

  task automatic test_midframe();
    start_row = 5'd3;
    set_pixel(10'd0, 10'd200, 1'b1);
    step();
    capture(0);
    step();
    capture(1);
    pulse_vsync();
    set_pixel(10'd0, 10'd200, 1'b1);
    step();
    capture(2);
    tests_run++;
    if ({cap_addr[0], cap_addr[1]} !== {12'd880, 12'd880}) begin
      tests_failed++;
      $display("[TB] FAIL midframe_hold: got %0d %0d, expected 880 880", cap_addr[0], cap_addr[1]);
    end
    tests_run++;
    if (cap_addr[2] !== 12'd1200) begin
      tests_failed++;
      $display("[TB] FAIL midframe_new: got %0d, expected 1200", cap_addr[2]);
    end
  endtask

  task automatic test_reset_midline();
    start_row = 5'd0;
    set_pixel(10'd3, 10'd0, 1'b1);
    hsync_in = 1'b0;
    for (int n = 0; n < 3; n++) step();
    reset_n = 1'b0;
    step();
    tests_run++;
    if ({rgb, active_out, hsync_out, char_addr} !== {6'd0, 1'b0, 1'b1, 12'd0}) begin
      tests_failed++;
      $display("[TB] FAIL midline_reset: got rgb=%h act=%b hs=%b ca=%h, expected 00 0 1 000",
               rgb, active_out, hsync_out, char_addr);
    end
    hsync_in = 1'b1;
    reset_n  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      capture(n);
    end
    for (int n = 0; n < 4; n++) begin
      tests_run++;
      if ({cap_rgb[n], cap_act[n]} !== {6'd0, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL release_flush[%0d]: got %h act=%b, expected 00 act=0", n, cap_rgb[n], cap_act[n]);
      end
    end
    tests_run++;
    if ({cap_rgb[4], cap_act[4]} !== {6'h2A, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL release_first: got %h act=%b, expected 2a act=1", cap_rgb[4], cap_act[4]);
    end
  endtask

`ifdef TEXT_CURSOR_EN
  task automatic test_cursor();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) pulse_vsync();
    cursor_on  = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    for (int n = 0; n < 7; n++) begin
      if (n == 0)      set_pixel(10'd40, 10'd46, 1'b1);
      else if (n == 1) set_pixel(10'd41, 10'd46, 1'b1);
      else if (n == 2) set_pixel(10'd40, 10'd45, 1'b1);
      else             set_pixel(10'd0, 10'd0, 1'b0);
      step();
      capture(n);
    end
    tests_run++;
    if ({cap_rgb[4], cap_rgb[5], cap_rgb[6]} !== {6'h00, 6'h00, 6'h2A}) begin
      tests_failed++;
      $display("[TB] FAIL cursor_shown: got %h %h %h, expected 00 00 2a", cap_rgb[4], cap_rgb[5], cap_rgb[6]);
    end
    for (int i = 0; i < 16; i++) pulse_vsync();
    for (int n = 0; n < 5; n++) begin
      if (n == 0) set_pixel(10'd40, 10'd46, 1'b1);
      else        set_pixel(10'd0, 10'd0, 1'b0);
      step();
      capture(n);
    end
    tests_run++;
    if (cap_rgb[4] !== 6'h2A) begin
      tests_failed++;
      $display("[TB] FAIL cursor_hidden: got %h, expected 2a", cap_rgb[4]);
    end
    cursor_on = 1'b0;
  endtask
`else
  task automatic test_cursor();
    cursor_on  = 1'b1;
    cursor_col = 7'd0;
    cursor_row = 5'd0;
    for (int n = 0; n < 6; n++) begin
      if (n < 2) set_pixel(10'(n), 10'd14, 1'b1);
      else       set_pixel(10'd0, 10'd0, 1'b0);
      step();
      capture(n);
    end
    tests_run++;
    if ({cap_rgb[4], cap_rgb[5]} !== {6'h2A, 6'h2A}) begin
      tests_failed++;
      $display("[TB] FAIL cursor_ignored: got %h %h, expected 2a 2a", cap_rgb[4], cap_rgb[5]);
    end
    cursor_on = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) begin
      char_mem[i] = 16'h0720;
      font_mem[i] = 8'h00;
    end
    for (int i = 0; i < 16; i++) pal_mem[i] = 6'(i + 16);
    pal_mem[0]  = 6'h00;
    pal_mem[7]  = 6'h2A;
    pal_mem[1]  = 6'h0C;
    pal_mem[14] = 6'h33;
    char_mem[0]   = 16'h0741;
    char_mem[1]   = 16'h1E42;
    char_mem[165] = 16'h0741;
    font_mem[12'h410] = 8'h18;
    font_mem[12'h41D] = 8'hFF;
    font_mem[12'h41E] = 8'hFF;
    font_mem[12'h420] = 8'h10;
    font_mem[12'h422] = 8'hA5;

    reset_n    = 1'b0;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    start_row  = 5'd0;
    cursor_on  = 1'b0;
    cursor_col = 7'd0;
    cursor_row = 5'd0;
    set_pixel(10'd0, 10'd0, 1'b0);

    test_reset();
    test_basic();
    test_attr();
    test_inactive();
    test_sync_latency();
    test_ring();
    test_midframe();
    test_reset_midline();
    test_cursor();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
